lsu_bus_bridge: RTL and testbench

Memory-stage load/store bridge between the pipelined datapath and the data-memory bus. It takes the M-stage access (word address from ALUResultM, lane-shifted write data and byte enables from the write-side byte-enable logic) and runs it as a request/grant/response bus transaction. It stalls the pipeline until the transaction completes, then presents the raw read word where the datapath's ReadData input expects it. The W-stage byte-enable logic does the lane extraction and sign extension.

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_watchdog.sv | 31 +++
 rtl/lsu_bus_bridge.sv | 127 ++++++++++++
 tb/tb_lsu_bus_bridge.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the memory-stage load/store bus bridge.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    DONE
  } lsu_state_t;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_req_t;

  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/lsu_watchdog.sv
// Saturating cycle counter that flags the last permitted cycle of a bus access.
module lsu_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] MAX  = W'(TIMEOUT_CYCLES);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && count != MAX) begin
      count <= count + W'(1);
    end
  end

  // Fires during the TIMEOUT_CYCLES-th enabled cycle so the abort lands on that edge.
  assign expired = en && (count >= LAST);

endmodule

// File: rtl/lsu_bus_bridge.sv
// M-stage load/store bridge: runs one req/gnt/rvalid bus transaction per access
// and stalls the pipeline until the access completes.
module lsu_bus_bridge
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_enable,
  output logic        stall_m,
  output logic [31:0] rdata,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  lsu_state_t  state;
  bus_req_t    req_q;
  logic        req_v;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        access;
  logic        wd_clr;
  logic        wd_en;
  logic        wd_expired;

  assign access = mem_rd | mem_wr;

  // Depends only on state and the M-stage controls, never on bus inputs.
  assign stall_m = ((state == IDLE) && access) || (state == REQ) || (state == WAIT_R);

  assign wd_clr = (state == IDLE) && access;
  assign wd_en  = (state == REQ) || (state == WAIT_R);

  lsu_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .n_rst   (n_rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      req_q   <= '0;
      req_v   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (bus_rvalid && state != WAIT_R) begin
        err_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (access) begin
            req_q.we    <= mem_wr;
            req_q.addr  <= word_addr(addr);
            req_q.wdata <= wdata;
            req_q.be    <= mem_wr ? byte_enable : 4'hF;
            if (mem_rd && mem_wr) begin
              err_q <= 1'b1;
            end
            if (mem_wr && byte_enable == '0) begin
              state <= DONE;
            end else begin
              state <= REQ;
              req_v <= 1'b1;
            end
          end
        end
        REQ: begin
          if (wd_expired) begin
            state <= DONE;
            req_v <= 1'b0;
            err_q <= 1'b1;
            if (!req_q.we) begin
              rdata_q <= ERR_RDATA;
            end
          end else if (bus_gnt) begin
            req_v <= 1'b0;
            state <= req_q.we ? DONE : WAIT_R;
          end
        end
        WAIT_R: begin
          if (wd_expired) begin
            state   <= DONE;
            err_q   <= 1'b1;
            rdata_q <= ERR_RDATA;
          end else if (bus_rvalid) begin
            state   <= DONE;
            rdata_q <= bus_rdata;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign rdata     = rdata_q;
  assign err       = err_q;
  assign bus_req   = req_v;
  assign bus_we    = req_q.we;
  assign bus_addr  = req_q.addr;
  assign bus_wdata = req_q.wdata;
  assign bus_be    = req_q.be;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Bench for lsu_bus_bridge: a timeline model per access, checked every cycle,
// against a default-timeout instance and a TIMEOUT_CYCLES=4 instance.
module tb_lsu_bus_bridge;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        mem_rd, mem_wr;
  logic [31:0] addr, wdata;
  logic [3:0]  byte_enable;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;
  logic        sel;

  logic        stall_a, err_a, req_a, we_a;
  logic [31:0] rdata_a, baddr_a, bwdata_a;
  logic [3:0]  be_a;
  logic        stall_b, err_b, req_b, we_b;
  logic [31:0] rdata_b, baddr_b, bwdata_b;
  logic [3:0]  be_b;

  logic        stall_o, err_o, req_o, we_o;
  logic [31:0] rdata_o, baddr_o, bwdata_o;
  logic [3:0]  be_o;

  logic        exp_stall, exp_req, exp_err, exp_we;
  logic [31:0] exp_rdata, exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  logic        chk_on = 1'b0;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          stall_total = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] cap_addr = '0;
  logic [31:0] cap_rdata = '0;
  logic [3:0]  cap_be = '0;
  logic        cap_we = 1'b0;

  always #5 clk = ~clk;

  lsu_bus_bridge dut_a (
    .clk         (clk),
    .n_rst       (n_rst),
    .mem_rd      (mem_rd & ~sel),
    .mem_wr      (mem_wr & ~sel),
    .addr        (addr),
    .wdata       (wdata),
    .byte_enable (byte_enable),
    .stall_m     (stall_a),
    .rdata       (rdata_a),
    .err         (err_a),
    .bus_req     (req_a),
    .bus_we      (we_a),
    .bus_addr    (baddr_a),
    .bus_wdata   (bwdata_a),
    .bus_be      (be_a),
    .bus_gnt     (bus_gnt & ~sel),
    .bus_rvalid  (bus_rvalid & ~sel),
    .bus_rdata   (bus_rdata)
  );

  lsu_bus_bridge #(
    .TIMEOUT_CYCLES(4)
  ) dut_b (
    .clk         (clk),
    .n_rst       (n_rst),
    .mem_rd      (mem_rd & sel),
    .mem_wr      (mem_wr & sel),
    .addr        (addr),
    .wdata       (wdata),
    .byte_enable (byte_enable),
    .stall_m     (stall_b),
    .rdata       (rdata_b),
    .err         (err_b),
    .bus_req     (req_b),
    .bus_we      (we_b),
    .bus_addr    (baddr_b),
    .bus_wdata   (bwdata_b),
    .bus_be      (be_b),
    .bus_gnt     (bus_gnt & sel),
    .bus_rvalid  (bus_rvalid & sel),
    .bus_rdata   (bus_rdata)
  );

  assign stall_o  = sel ? stall_b  : stall_a;
  assign err_o    = sel ? err_b    : err_a;
  assign req_o    = sel ? req_b    : req_a;
  assign we_o     = sel ? we_b     : we_a;
  assign rdata_o  = sel ? rdata_b  : rdata_a;
  assign baddr_o  = sel ? baddr_b  : baddr_a;
  assign bwdata_o = sel ? bwdata_b : bwdata_a;
  assign be_o     = sel ? be_b     : be_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("stall_m", 32'(stall_o), 32'(exp_stall));
      chk("bus_req", 32'(req_o), 32'(exp_req));
      chk("err", 32'(err_o), 32'(exp_err));
      chk("rdata", rdata_o, exp_rdata);
      if (exp_req || !n_rst) begin
        chk("bus_we", 32'(we_o), 32'(exp_we));
        chk("bus_addr", baddr_o, exp_addr);
        chk("bus_be", 32'(be_o), 32'(exp_be));
        if (exp_we || !n_rst) chk("bus_wdata", bwdata_o, exp_wdata);
      end
      if (stall_o) stall_total++;
      if (req_o) begin
        cap_addr = baddr_o;
        cap_be   = be_o;
        cap_we   = we_o;
      end
      if (prev_stall && !stall_o) cap_rdata = rdata_o;
      prev_stall = stall_o;
    end
  end

  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // g: REQ cycles without grant; d: cycles from grant to rvalid; lit_stall: hand-computed stall length.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input int g, input int d, input logic [31:0] rv,
                        input int lit_stall);
    int   tmo, r, n, act, reqc, s0;
    logic store, skip, abort;
    tmo   = sel ? 4 : 255;
    store = wr;
    skip  = wr && (be == 4'h0);
    r     = g + 1;
    n     = store ? r : r + d;
    abort = !skip && (n >= tmo);
    act   = skip ? 0 : (abort ? tmo : n);
    reqc  = skip ? 0 : ((r < act) ? r : act);
    exp_we    = store;
    exp_addr  = {a[31:2], 2'b00};
    exp_wdata = wd;
    exp_be    = store ? be : 4'hF;
    mem_rd = rd; mem_wr = wr; addr = a; wdata = wd; byte_enable = be;
    s0 = stall_total;
    for (int c = 0; c <= act + 1; c++) begin
      exp_stall  = (c <= act);
      exp_req    = (c >= 1) && (c <= reqc);
      bus_gnt    = !skip && (c == r);
      bus_rvalid = !skip && !store && (c == r + d);
      bus_rdata  = bus_rvalid ? rv : 32'h0;
      if (c == 1 && rd && wr) exp_err = 1'b1;
      if (c == act + 1) begin
        if (abort) exp_err = 1'b1;
        if (!store) exp_rdata = abort ? 32'hDEAD_BEEF : rv;
      end
      step();
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    chk("stall_cycles", 32'(stall_total - s0), 32'(lit_stall));
  endtask

  task automatic idle(input int n, input logic spur);
    mem_rd = 1'b0; mem_wr = 1'b0;
    exp_stall = 1'b0; exp_req = 1'b0;
    for (int c = 0; c < n; c++) begin
      bus_rvalid = spur && (c == 0);
      bus_rdata  = 32'h5555_5555;
      if (spur && c == 1) exp_err = 1'b1;
      step();
    end
    bus_rvalid = 1'b0; bus_rdata = '0;
  endtask

  initial begin
    sel = 1'b0; n_rst = 1'b0;
    mem_rd = 1'b0; mem_wr = 1'b0; addr = '0; wdata = '0; byte_enable = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    exp_stall = 1'b0; exp_req = 1'b0; exp_err = 1'b0; exp_we = 1'b0;
    exp_rdata = '0; exp_addr = '0; exp_wdata = '0; exp_be = '0;
    chk_on = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 n_rst = 1'b1;
    idle(2, 1'b0);

    access(1'b0, 1'b1, 32'h2000_0006, 32'hABCD_0000, 4'b1100, 0, 0, 32'h0, 2);
    chk("store_addr", cap_addr, 32'h2000_0004);
    chk("store_be", 32'(cap_be), 32'h0000_000C);
    chk("store_we", 32'(cap_we), 32'h1);

    access(1'b1, 1'b0, 32'h2000_0010, 32'h0, 4'h0, 3, 2, 32'h1234_5678, 7);
    chk("load_rdata", cap_rdata, 32'h1234_5678);
    chk("load_be", 32'(cap_be), 32'h0000_000F);

    access(1'b1, 1'b0, 32'h2000_0104, 32'h0, 4'h0, 0, 1, 32'hCAFE_F00D, 3);
    access(1'b0, 1'b1, 32'h2000_0108, 32'h1111_2222, 4'hF, 1, 0, 32'h0, 3);
    idle(2, 1'b0);
    access(1'b0, 1'b1, 32'h2000_0020, 32'h9999_9999, 4'h0, 0, 0, 32'h0, 1);
    access(1'b1, 1'b0, 32'h3000_000F, 32'h0, 4'h0, 2, 4, 32'h0F0F_0F0F, 8);
    access(1'b1, 1'b1, 32'h2000_0031, 32'h0000_BEEF, 4'b0011, 0, 0, 32'h0, 2);
    chk("both_err", 32'(err_o), 32'h1);
    idle(1, 1'b0);

    // Reset while waiting for read data.
    mem_rd = 1'b1; mem_wr = 1'b0; addr = 32'h2000_0040; wdata = '0; byte_enable = '0;
    exp_stall = 1'b1; exp_req = 1'b0; exp_we = 1'b0; exp_addr = 32'h2000_0040; exp_be = 4'hF;
    step();
    bus_gnt = 1'b1; exp_req = 1'b1;
    step();
    bus_gnt = 1'b0; exp_req = 1'b0;
    @(negedge clk); #2;
    n_rst = 1'b0; mem_rd = 1'b0;
    #1;
    exp_stall = 1'b0; exp_req = 1'b0; exp_err = 1'b0; exp_rdata = '0;
    exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_be = '0;
    chk("rst_stall", 32'(stall_o), 32'h0);
    chk("rst_req", 32'(req_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_addr", baddr_o, 32'h0);
    chk("rst_be", 32'(be_o), 32'h0);
    @(negedge clk);
    @(posedge clk); #1 n_rst = 1'b1;
    idle(1, 1'b0);
    access(1'b1, 1'b0, 32'h2000_0044, 32'h0, 4'h0, 0, 1, 32'h7777_0001, 3);
    chk("post_rst_rdata", cap_rdata, 32'h7777_0001);
    idle(3, 1'b1);
    chk("spur_err", 32'(err_o), 32'h1);

    // Short-timeout instance.
    sel = 1'b1; exp_err = 1'b0; exp_rdata = '0;
    idle(1, 1'b0);
    access(1'b1, 1'b0, 32'h2000_0050, 32'h0, 4'h0, 100, 1, 32'h0, 5);
    chk("abort_rdata", cap_rdata, 32'hDEAD_BEEF);
    idle(3, 1'b0);
    chk("err_sticky", 32'(err_o), 32'h1);
    access(1'b1, 1'b0, 32'h2000_0054, 32'h0, 4'h0, 0, 2, 32'h2468_ACE0, 4);
    chk("b_load_rdata", cap_rdata, 32'h2468_ACE0);
    access(1'b1, 1'b0, 32'h2000_0058, 32'h0, 4'h0, 1, 2, 32'h1357_9BDF, 5);
    chk("abort_vs_rvalid", cap_rdata, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 32'h2000_005C, 32'h0, 4'h0, 3, 1, 32'h0, 5);
    access(1'b0, 1'b1, 32'h2000_0060, 32'h5A5A_5A5A, 4'hF, 3, 0, 32'h0, 5);
    access(1'b0, 1'b1, 32'h2000_0064, 32'hA5A5_A5A5, 4'b0101, 2, 0, 32'h0, 4);
    idle(2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL time_limit: got running expected finished");
    $fatal(1);
  end

endmodule
